// File: rtl/flash_programmer.sv
// flash_programmer: erases every block covering [base_addr, base_addr+word_count) and then
//   programs the range word by word from a source stream, optionally verifying each word.
// Latency: one driver command per state pair; every *_WAIT lasts at least two cycles.
// Backpressure: src_ready pulses only in FETCH with src_valid high; src stalls are unbounded.
// Optional feature: define FLASH_PROGRAMMER_VERIFY_EN for per-word read-back compare.
// Ports: clk/rst (async, active-high); start/abort job control; base_addr/word_count job;
//   src_valid/src_data/src_ready word source; busy/done/error/err_addr/words_done status;
//   drv_* flash driver command/address/data interface with drv_busy handshake.
module flash_programmer #(
   parameter int FLASH_ADDR_SIZE = 22,
   parameter int BLOCK_ADDR_BITS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [FLASH_ADDR_SIZE-1:0] base_addr,
   input  logic [FLASH_ADDR_SIZE:0]   word_count,
   input  logic                       src_valid,
   input  logic [15:0]                src_data,
   output logic                       src_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [FLASH_ADDR_SIZE-1:0] err_addr,
   output logic [FLASH_ADDR_SIZE:0]   words_done,
   output logic [FLASH_ADDR_SIZE-1:0] drv_addr,
   output logic [15:0]                drv_data_in,
   input  logic [15:0]                drv_data_out,
   output logic                       drv_enable_read,
   output logic                       drv_enable_erase,
   output logic                       drv_enable_write,
   input  logic                       drv_busy
);
   localparam int AW = FLASH_ADDR_SIZE;
   localparam int BB = BLOCK_ADDR_BITS;
   localparam int BW = FLASH_ADDR_SIZE - BLOCK_ADDR_BITS;

   typedef enum logic [3:0] {
      IDLE,
      ER_ISSUE,
      ER_WAIT,
      FETCH,
      WR_ISSUE,
      WR_WAIT,
`ifdef FLASH_PROGRAMMER_VERIFY_EN
      RD_ISSUE,
      RD_WAIT,
      RD_CHECK,
`endif
      FINISH
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic [BW-1:0]   block_q;
   logic [AW+1:0]   blocks_rem_q;   // erase blocks still to issue after the current one
   logic [AW:0]     count_q;
   logic [AW:0]     done_cnt_q;
   logic [15:0]     data_q;
   logic            first_q;        // high during the first cycle spent in a state
   logic [AW+1:0]   span_blocks;
   logic            wait_exit;
   logic            last_word;
   logic            advance;

   // Number of block boundaries crossed by the range; only meaningful for word_count != 0.
   assign span_blocks = ({{(AW+2-BB){1'b0}}, base_addr[BB-1:0]} + {1'b0, word_count}
                         - (AW+2)'(1)) >> BB;

   // The driver may raise drv_busy a cycle after the command, so the first wait cycle is blind.
   assign wait_exit = !first_q && !drv_busy;
   assign last_word = (done_cnt_q + (AW+1)'(1)) == count_q;

`ifdef FLASH_PROGRAMMER_VERIFY_EN
   logic            error_q;
   logic [AW-1:0]   err_addr_q;
   logic            mismatch;
   assign mismatch = drv_data_out != data_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start && !drv_busy) state_d = (word_count == '0) ? FINISH : ER_ISSUE;
         ER_ISSUE: state_d = ER_WAIT;
         ER_WAIT:  if (wait_exit) begin
                      if (abort)                  state_d = FINISH;
                      else if (blocks_rem_q != '0) state_d = ER_ISSUE;
                      else                        state_d = FETCH;
                   end
         FETCH:    if (abort)          state_d = FINISH;
                   else if (src_valid) state_d = WR_ISSUE;
         WR_ISSUE: state_d = WR_WAIT;
`ifdef FLASH_PROGRAMMER_VERIFY_EN
         WR_WAIT:  if (wait_exit) state_d = abort ? FINISH : RD_ISSUE;
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT:  if (wait_exit) state_d = abort ? FINISH : RD_CHECK;
         // words_done was already bumped on WR_WAIT exit
         RD_CHECK: if (mismatch || done_cnt_q == count_q) state_d = FINISH;
                   else                                   state_d = FETCH;
`else
         WR_WAIT:  if (wait_exit) state_d = (abort || last_word) ? FINISH : FETCH;
`endif
         FINISH:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Moving to FETCH from anywhere but erase means the previous word is finished.
   assign advance = (state_d == FETCH) && (state_q != FETCH) && (state_q != ER_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= '0;
         block_q      <= '0;
         blocks_rem_q <= '0;
         count_q      <= '0;
         done_cnt_q   <= '0;
         data_q       <= '0;
         first_q      <= 1'b0;
      end else begin
         first_q <= state_d != state_q;
         if (state_q == IDLE && state_d != IDLE) begin
            addr_q       <= base_addr;
            block_q      <= base_addr[AW-1:BB];
            blocks_rem_q <= span_blocks;
            count_q      <= word_count;
            done_cnt_q   <= '0;
         end
         if (state_q == ER_WAIT && state_d == ER_ISSUE) begin
            block_q      <= block_q + BW'(1);
            blocks_rem_q <= blocks_rem_q - (AW+2)'(1);
         end
         if (state_q == FETCH && state_d == WR_ISSUE) data_q <= src_data;
         if (state_q == WR_WAIT && wait_exit) done_cnt_q <= done_cnt_q + (AW+1)'(1);
         if (advance) addr_q <= addr_q + AW'(1);
      end
   end

`ifdef FLASH_PROGRAMMER_VERIFY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else if (state_q == IDLE && state_d != IDLE) begin
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else if (state_q == RD_CHECK && mismatch) begin
         error_q    <= 1'b1;
         err_addr_q <= addr_q;
      end
   end

   assign error           = error_q;
   assign err_addr        = err_addr_q;
   assign drv_enable_read = (state_q == RD_ISSUE) || (state_q == RD_WAIT) || (state_q == RD_CHECK);
`else
   logic unused_rd_data;
   assign unused_rd_data  = ^drv_data_out;
   assign error           = 1'b0;
   assign err_addr        = '0;
   assign drv_enable_read = 1'b0;
`endif

   assign busy             = (state_q != IDLE) && (state_q != FINISH);
   assign done             = state_q == FINISH;
   assign src_ready        = (state_q == FETCH) && src_valid && !abort;
   assign words_done       = done_cnt_q;
   assign drv_enable_erase = state_q == ER_ISSUE;
   assign drv_enable_write = state_q == WR_ISSUE;
   assign drv_addr         = (state_q == ER_ISSUE || state_q == ER_WAIT) ? {block_q, {BB{1'b0}}}
                                                                         : addr_q;
   assign drv_data_in      = data_q;
endmodule
